rv_muldiv_unit: RTL and testbench

//  Iterative RV-M multiply/divide unit for the EX stage of the pipelined core.

---
 rtl/rv_muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV-M multiply/divide, one radix-2 step per cycle.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
//  state | meaning
//  IDLE  | waiting for an accepted start
//  CALC  | XLEN shift-add multiply / restoring divide steps
//  FIX   | sign fix-up, hi/lo or quotient/remainder select, W-op extension
//  DONE  | result valid, done pulse
module rv_muldiv_unit #(
  parameter int XLEN      = 64,
  parameter bit SUPPORT_W = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            word_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int            CW   = $clog2(XLEN);
  localparam bit            W_EN = SUPPORT_W && (XLEN == 64);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_mcand;
  logic            r_is_div, r_want_hi, r_neg, r_word;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic            w_is_div, w_word, w_a_sgn, w_b_sgn, w_want_hi, w_sa, w_sb;
  logic            w_div0, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_abs_a, w_abs_b, w_min, w_fast_res;

  // MUL is computed unsigned: the low half of the product does not depend on signedness.
  always_comb begin
    w_is_div  = funct3[2];
    w_word    = W_EN && word_op;
    w_a_sgn   = w_is_div ? !funct3[0]
                         : (!w_word && (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10));
    w_b_sgn   = w_is_div ? !funct3[0] : (!w_word && funct3[1:0] == 2'b01);
    w_want_hi = w_is_div ? funct3[1] : (!w_word && funct3[1:0] != 2'b00);
    w_a_ext   = op_a;
    w_b_ext   = op_b;
    if (w_word) begin
      w_a_ext = w_a_sgn ? sext32(op_a[31:0]) : XLEN'(op_a[31:0]);
      w_b_ext = w_b_sgn ? sext32(op_b[31:0]) : XLEN'(op_b[31:0]);
    end
    w_sa       = w_a_sgn && w_a_ext[XLEN-1];
    w_sb       = w_b_sgn && w_b_ext[XLEN-1];
    w_abs_a    = w_sa ? -w_a_ext : w_a_ext;
    w_abs_b    = w_sb ? -w_b_ext : w_b_ext;
    w_min      = w_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    w_div0     = w_is_div && (w_b_ext == '0);
    w_ovf      = w_is_div && !funct3[0] && (w_a_ext == w_min) && (w_b_ext == '1);
    w_fast     = w_div0 || w_ovf;
    w_fast_res = w_div0 ? (w_want_hi ? w_a_ext : '1) : (w_want_hi ? '0 : w_a_ext);
    if (w_word) w_fast_res = sext32(w_fast_res[31:0]);
    w_accept   = (r_state == S_IDLE) && start && !flush;
  end

  logic [XLEN:0]   w_sum, w_rsh, w_diff;
  logic [XLEN-1:0] w_step_hi, w_step_lo;

  // Divide: the borrow out of the trial subtraction is the inverted quotient bit.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    w_rsh  = {r_hi, r_lo[XLEN-1]};
    w_diff = w_rsh - {1'b0, r_mcand};
    if (r_is_div) begin
      w_step_hi = w_diff[XLEN] ? w_rsh[XLEN-1:0] : w_diff[XLEN-1:0];
      w_step_lo = {r_lo[XLEN-2:0], !w_diff[XLEN]};
    end else begin
      w_step_hi = w_sum[XLEN:1];
      w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_qr, w_fix_res;

  always_comb begin
    w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_qr   = r_want_hi ? r_hi : r_lo;
    if (r_neg) w_qr = -w_qr;
    if (r_is_div) w_fix_res = w_qr;
    else          w_fix_res = r_want_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    if (r_word) w_fix_res = sext32(w_fix_res[31:0]);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (flush) w_next = S_IDLE;
               else if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_is_div  <= 1'b0;
      r_want_hi <= 1'b0;
      r_neg     <= 1'b0;
      r_word    <= 1'b0;
    end else if (w_accept) begin
      r_is_div  <= w_is_div;
      r_want_hi <= w_want_hi;
      r_word    <= w_word;
      r_neg     <= (w_is_div && w_want_hi) ? w_sa : (w_sa ^ w_sb);
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= w_is_div ? w_abs_a : w_abs_b;
      r_mcand   <= w_is_div ? w_abs_b : w_abs_a;
      if (w_fast) result <= w_fast_res;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + CW'(1);
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
    end else if (r_state == S_FIX && !flush) begin
      result <= w_fix_res;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Bench for rv_muldiv_unit (XLEN=64, W-ops on): transaction-level model with
// plain 128-bit / 32-bit arithmetic, per-cycle compare, directed literal cases.
module tb_rv_muldiv_unit;
  localparam int          XLEN = 64;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, start, word_op, flush, busy, done;
  logic [2:0]  funct3;
  logic [63:0] op_a, op_b, result;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(XLEN), .SUPPORT_W(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .word_op(word_op),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_op(input logic [2:0] f, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  a32, b32;
    logic [31:0]         ua32, ub32, q32, r32;
    logic [63:0]         q, r;
    if (!f[2]) begin
      if (w) return sx32(a[31:0] * b[31:0]);
      pa = (f == 3'd3) ? $signed({64'd0, a}) : $signed({{64{a[63]}}, a});
      pb = (f == 3'd1) ? $signed({{64{b[63]}}, b}) : $signed({64'd0, b});
      p  = pa * pb;
      return (f == 3'd0) ? p[63:0] : p[127:64];
    end
    if (w) begin
      a32 = a[31:0]; b32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      if (ub32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = ua32;
      end else if (!f[0]) begin
        if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) begin
          q32 = ua32; r32 = 32'd0;
        end else begin
          q32 = a32 / b32; r32 = a32 % b32;
        end
      end else begin
        q32 = ua32 / ub32; r32 = ua32 % ub32;
      end
      return sx32(f[1] ? r32 : q32);
    end
    sa = a; sb = b;
    if (b == 64'd0) begin
      q = ONES; r = a;
    end else if (!f[0]) begin
      if (a == MIN && b == ONES) begin
        q = MIN; r = 64'd0;
      end else begin
        q = sa / sb; r = sa % sb;
      end
    end else begin
      q = a / b; r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    if (!f[2]) return 1'b0;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == MIN && b == ONES));
    return zero || ovf;
  endfunction

  // Transaction model: an accepted op stays busy for L+1 cycles (L = 0 or XLEN+1),
  // publishes its result L edges after acceptance and pulses done on the last one.
  bit          m_active = 1'b0;
  int          m_cnt    = 0;
  logic [63:0] m_result = '0;
  logic [63:0] m_pending;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      m_result = '0;
    end else if (m_active) begin
      if (flush || m_cnt == 0) m_active = 1'b0;
      else begin
        m_cnt--;
        if (m_cnt == 0) m_result = m_pending;
      end
    end else if (start && !flush) begin
      m_active  = 1'b1;
      m_pending = ref_op(funct3, word_op, op_a, op_b);
      m_cnt     = is_fast(funct3, word_op, op_a, op_b) ? 0 : XLEN + 1;
      if (m_cnt == 0) m_result = m_pending;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== m_active) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_active);
      end
      checks++;
      if (done !== (m_active && m_cnt == 0)) begin
        errors++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, (m_active && m_cnt == 0));
      end
      checks++;
      if (result !== m_result) begin
        errors++;
        $display("FAIL result cyc=%0d got=%h exp=%h", cyc, result, m_result);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; word_op = w; op_a = a; op_b = b;
    @(posedge clk); #1;
    start   = 1'b0;
    op_a    = {$urandom, $urandom};
    op_b    = {$urandom, $urandom};
    funct3  = 3'($urandom);
    word_op = 1'($urandom);
  endtask

  // n = index of the negedge (1 = first one after the accepting edge) showing done.
  task automatic wait_done(output int n, output logic [63:0] res);
    n = 0; res = '0;
    for (int i = 1; i <= XLEN + 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i; res = result;
        break;
      end
      start = ($urandom_range(0, 5) == 0);
    end
    start = 1'b0;
    if (n == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout cyc=%0d got=no_done exp=done_within_%0d", cyc, XLEN + 8);
    end
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] lit, input int lat);
    int n;
    logic [63:0] res;
    checks++;
    if (ref_op(f, w, a, b) !== lit) begin
      errors++;
      $display("FAIL model_%s got=%h exp=%h", name, ref_op(f, w, a, b), lit);
    end
    issue(f, w, a, b);
    wait_done(n, res);
    if (n != 0) begin
      checks++;
      if (res !== lit) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", name, res, lit);
      end
      checks++;
      if (n != lat) begin
        errors++;
        $display("FAIL latency_%s got=%0d exp=%0d", name, n, lat);
      end
    end
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] ra, rb, res;
    logic [2:0]  rf;
    logic        rw;
    int          n;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; word_op = 1'b0;
    op_a = '0; op_b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 64'd0)  begin errors++; $display("FAIL reset_result got=%h exp=0", result); end

    directed("mul_7_m3",   3'd0, 1'b0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, XLEN + 2);
    directed("mulhu",      3'd3, 1'b0, ONES, 64'd2, 64'd1, XLEN + 2);
    directed("mulh_m1m1",  3'd1, 1'b0, ONES, ONES, 64'd0, XLEN + 2);
    directed("mulhsu",     3'd2, 1'b0, ONES, 64'd2, ONES, XLEN + 2);
    directed("div_m7_2",   3'd4, 1'b0, -64'd7, 64'd2, -64'd3, XLEN + 2);
    directed("rem_m7_2",   3'd6, 1'b0, -64'd7, 64'd2, ONES, XLEN + 2);
    directed("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, XLEN + 2);
    directed("remu_100_7", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, XLEN + 2);
    directed("div_by0",    3'd4, 1'b0, 64'd5, 64'd0, ONES, 1);
    directed("rem_by0",    3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    directed("div_ovf",    3'd4, 1'b0, MIN, ONES, MIN, 1);
    directed("rem_ovf",    3'd6, 1'b0, MIN, ONES, 64'd0, 1);
    directed("divw_ovf",   3'd4, 1'b1, 64'h0000_0001_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1);
    directed("mulw",       3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, XLEN + 2);

    // flush on the 10th edge after acceptance
    issue(3'd5, 1'b0, 64'd1000, 64'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL flush_result got=%h exp=%h", result, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    repeat (XLEN + 4) @(posedge clk);
    directed("divu_after_flush", 3'd5, 1'b0, 64'd1000, 64'd7, 64'd142, XLEN + 2);

    // start dropped when it coincides with flush in IDLE
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'd4; word_op = 1'b0; op_a = 64'd9; op_b = 64'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got=%b exp=0", busy); end

    // reset mid-CALC
    issue(3'd5, 1'b0, 64'd123456, 64'd11);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL rst_mid_result got=%h exp=0", result); end

    for (int k = 0; k < 300; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 11))
        0: rb = 64'd0;
        1: rb = ONES;
        2: ra = MIN;
        3: begin ra = MIN; rb = ONES; end
        4: begin ra[31:0] = 32'h8000_0000; rb[31:0] = 32'hFFFF_FFFF; end
        5: begin ra = 64'($urandom_range(0, 200)); rb = 64'($urandom_range(0, 20)); end
        6: begin ra = -64'($urandom_range(0, 200)); rb = 64'($urandom_range(1, 20)); end
        7: rb[31:0] = 32'd0;
        default: ;
      endcase
      rf = 3'($urandom);
      rw = ($urandom_range(0, 3) == 0);
      issue(rf, rw, ra, rb);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, XLEN + 2)) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (2) @(posedge clk);
      end else begin
        wait_done(n, res);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
